// File: rtl/seq_match_search.sv
// rtl/seq_match_search.sv - multi-cycle linear search over a small valid-tagged register table
//
// comparator_eq    : structural N-bit equality (a == b -> out)
// seq_match_search : walks the table one entry per cycle looking for key
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_ena/addr/data table write port (sets the entry's valid bit)
//   clr              clears every valid bit, wins over a same-cycle write
//   start, key       search request, key latched when accepted
//   busy, done       search in progress / one-cycle result pulse
//   hit, hit_index   result of the last completed search

module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out
);

  logic [N-1:0] bit_eq;

  // Per-bit XNOR, then an AND reduction over all bit results.
  for (genvar g = 0; g < N; g++) begin : g_bit
    assign bit_eq[g] = ~(a[g] ^ b[g]);
  end

  assign out = &bit_eq;

endmodule

module seq_match_search #(
  parameter  int N     = 32,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_ena,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             clr,
  input  logic             start,
  input  logic [N-1:0]     key,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_index
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     entry [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     key_q;
  logic             eq;
  logic             match;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  comparator_eq #(.N(N)) u_cmp (
    .a   (entry[idx]),
    .b   (key_q),
    .out (eq)
  );

  // An entry that was never written (or was cleared) can never match,
  // whatever stale data it still holds.
  assign match = valid[idx] & eq;

  // Entry data carries no reset; only the valid bits define table contents.
  always_ff @(posedge clk) begin
    if (wr_ena) begin
      entry[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (wr_ena) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_index <= '0;
      idx       <= '0;
      key_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= key;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            hit       <= 1'b1;
            hit_index <= idx;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (idx == LAST_IDX) begin
            hit       <= 1'b0;
            hit_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Accepting start here lets back-to-back searches run with no idle gap.
          if (start) begin
            key_q <= key;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SEARCH;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_search.sv
// tb/tb_seq_match_search.sv - directed and randomized bench for seq_match_search
module tb_seq_match_search;

  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_ena;
  logic [IDX_W-1:0] wr_addr;
  logic [N-1:0]     wr_data;
  logic             clr;
  logic             start;
  logic [N-1:0]     key;
  logic             busy;
  logic             done;
  logic             hit;
  logic [IDX_W-1:0] hit_index;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] m_data  [DEPTH];
  logic         m_valid [DEPTH];
  logic         m_hit;
  int           m_idx;

  always #5 clk = ~clk;

  seq_match_search #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr       (clr),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_index (hit_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_hit = 1'b0;
    m_idx = 0;
  endtask

  task automatic write_entry(input int addr, input logic [N-1:0] data, input logic with_clr);
    wr_ena  = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = data;
    clr     = with_clr;
    step();
    wr_ena  = 1'b0;
    clr     = 1'b0;
    m_data[addr] = data;
    if (with_clr) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else begin
      m_valid[addr] = 1'b1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Reference: first valid entry equal to the key, else a miss after DEPTH compares.
  task automatic ref_search(input logic [N-1:0] k, output logic eh, output int ei, output int cyc);
    eh  = 1'b0;
    ei  = 0;
    cyc = DEPTH;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && m_data[i] == k) begin
        eh  = 1'b1;
        ei  = i;
        cyc = i + 1;
      end
    end
  endtask

  // Starts in the current cycle; returns positioned in the DONE cycle.
  task automatic run_search(input string tag, input logic [N-1:0] k);
    logic eh;
    int   ei;
    int   cyc;
    ref_search(k, eh, ei, cyc);
    start = 1'b1;
    key   = k;
    step();
    check({tag, " busy@start"}, 32'(busy), 32'd1);
    check({tag, " done@start"}, 32'(done), 32'd0);
    for (int c = 1; c <= cyc; c++) begin
      // Noise on start/key during the search must be ignored.
      start = 1'(($urandom % 2));
      key   = $urandom;
      step();
      if (c < cyc) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " hit hold"}, 32'(hit), 32'(m_hit));
        check({tag, " idx hold"}, 32'(hit_index), 32'(m_idx));
      end
    end
    start = 1'b0;
    m_hit = eh;
    m_idx = ei;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    check({tag, " hit"}, 32'(hit), 32'(m_hit));
    check({tag, " hit_index"}, 32'(hit_index), 32'(m_idx));
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_ena  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr     = 1'b0;
    start   = 1'b0;
    key     = '0;
    for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
    model_reset();
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset hit_index", 32'(hit_index), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Miss on an empty table, even for key 0 against unwritten entries.
    run_search("empty", 32'h0000_0000);
    step();

    for (int i = 0; i < DEPTH; i++) write_entry(i, 32'h10 + 32'(i), 1'b0);
    run_search("hit3", 32'h13);
    step();
    run_search("miss", 32'hDEAD_BEEF);
    step();

    write_entry(2, 32'hA5A5_A5A5, 1'b0);
    write_entry(5, 32'hA5A5_A5A5, 1'b0);
    run_search("dup", 32'hA5A5_A5A5);
    step();
    run_search("onebit", 32'hA5A5_A5A4);
    step();

    write_entry(6, 32'h0, 1'b1);
    run_search("clr+wr", 32'h0);
    step();
    write_entry(6, 32'h0, 1'b0);
    run_search("rewrite", 32'h0);

    for (int i = 0; i < DEPTH; i++) write_entry(i, 32'h10 + 32'(i), 1'b0);
    run_search("b2b a", 32'h13);
    run_search("b2b b", 32'h11);
    run_search("b2b c", 32'h17);
    step();

    // Asynchronous reset in the middle of a search.
    start = 1'b1;
    key   = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hit", 32'(hit), 32'd0);
    check("midrst hit_index", 32'(hit_index), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    run_search("postrst", 32'h13);
    step();

    // Randomized phase: small value alphabet so duplicates and hits are common.
    for (int it = 0; it < 30; it++) begin
      int nw;
      logic [N-1:0] k;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        write_entry($urandom_range(0, DEPTH - 1), 32'hC0DE_0000 | 32'($urandom_range(0, 5)),
                    1'($urandom_range(0, 9) == 0));
      end
      if ($urandom_range(0, 7) == 0) do_clr();
      k = 32'hC0DE_0000 | 32'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) k = $urandom;
      run_search($sformatf("rnd%0d", it), k);
      if ($urandom_range(0, 1) == 1) step();
    end

    step();
    check("final busy", 32'(busy), 32'd0);
    check("final done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
